// File: rtl/key_entry_sequencer.sv
// Turns PS/2 set-2 make codes into letter + digit + Enter board coordinates,
// with Backspace/Escape editing, break/extended prefix filtering and an idle timeout.
module key_entry_sequencer #(
  parameter int TIMEOUT_CYCLES = 27000000,
  parameter int CNT_W          = 25
) (
  input  logic       clock27,
  input  logic       reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  output logic       entry_valid,
  output logic [3:0] entry_letter,
  output logic [3:0] entry_number,
  output logic [3:0] cur_letter,
  output logic [3:0] cur_number,
  output logic [1:0] phase,
  output logic       bad_key,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GOT_LETTER = 2'd1,
    GOT_NUMBER = 2'd2
  } phaseState;

  localparam logic [CNT_W-1:0] countLast = CNT_W'(TIMEOUT_CYCLES - 1);

  phaseState        state, stateNext;
  logic             brk, ext;
  logic [CNT_W-1:0] idleCount;
  logic             isMake, isLetter, isDigit, isEnter, isBack, isEsc, isEdit;
  logic [3:0]       letterIdx, digitIdx;
  logic             timeoutHit;
  logic [3:0]       curLetterNext, curNumberNext, entryLetterNext, entryNumberNext;
  logic             entryValidNext, badKeyNext, timeoutNext;

  // Bytes following an F0 or E0 prefix belong to break/extended codes and never reach the FSM.
  assign isMake  = scan_valid && !brk && !ext && (scan_code != 8'hF0) && (scan_code != 8'hE0);
  assign isEnter = (scan_code == 8'h5A);
  assign isBack  = (scan_code == 8'h66);
  assign isEsc   = (scan_code == 8'h76);
  assign isEdit  = isBack || isEsc;

  // A byte arriving in the same cycle as the expiry takes priority over the timeout.
  assign timeoutHit = !scan_valid && (state != IDLE) && (idleCount == countLast);
  assign phase      = state;

  always_comb begin
    isLetter  = 1'b1;
    letterIdx = 4'd0;
    case (scan_code)
      8'h1C: letterIdx = 4'd0;
      8'h32: letterIdx = 4'd1;
      8'h21: letterIdx = 4'd2;
      8'h23: letterIdx = 4'd3;
      8'h24: letterIdx = 4'd4;
      8'h2B: letterIdx = 4'd5;
      8'h34: letterIdx = 4'd6;
      8'h33: letterIdx = 4'd7;
      8'h43: letterIdx = 4'd8;
      8'h3B: letterIdx = 4'd9;
      default: isLetter = 1'b0;
    endcase
  end

  always_comb begin
    isDigit  = 1'b1;
    digitIdx = 4'd0;
    case (scan_code)
      8'h45: digitIdx = 4'd0;
      8'h16: digitIdx = 4'd1;
      8'h1E: digitIdx = 4'd2;
      8'h26: digitIdx = 4'd3;
      8'h25: digitIdx = 4'd4;
      8'h2E: digitIdx = 4'd5;
      8'h36: digitIdx = 4'd6;
      8'h3D: digitIdx = 4'd7;
      8'h3E: digitIdx = 4'd8;
      8'h46: digitIdx = 4'd9;
      default: isDigit = 1'b0;
    endcase
  end

  always_ff @(posedge clock27) begin
    if (reset) begin
      state        <= IDLE;
      brk          <= 1'b0;
      ext          <= 1'b0;
      idleCount    <= '0;
      cur_letter   <= 4'd0;
      cur_number   <= 4'd0;
      entry_letter <= 4'd0;
      entry_number <= 4'd0;
      entry_valid  <= 1'b0;
      bad_key      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= stateNext;
      cur_letter   <= curLetterNext;
      cur_number   <= curNumberNext;
      entry_letter <= entryLetterNext;
      entry_number <= entryNumberNext;
      entry_valid  <= entryValidNext;
      bad_key      <= badKeyNext;
      timeout      <= timeoutNext;
      if (scan_valid) begin
        if (scan_code == 8'hF0) begin
          brk <= 1'b1;
        end else if (scan_code == 8'hE0) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
        end
      end
      if (scan_valid || (state == IDLE) || timeoutHit) begin
        idleCount <= '0;
      end else if (idleCount != '1) begin
        idleCount <= idleCount + CNT_W'(1);
      end
    end
  end

  always_comb begin
    stateNext = state;
    if (isMake) begin
      case (state)
        IDLE: begin
          if (isLetter) stateNext = GOT_LETTER;
        end
        GOT_LETTER: begin
          if (isDigit) stateNext = GOT_NUMBER;
          else if (isEdit) stateNext = IDLE;
        end
        GOT_NUMBER: begin
          if (isEnter || isEsc) stateNext = IDLE;
          else if (isBack) stateNext = GOT_LETTER;
        end
        default: stateNext = IDLE;
      endcase
    end else if (timeoutHit) begin
      stateNext = IDLE;
    end
  end

  always_comb begin
    curLetterNext   = cur_letter;
    curNumberNext   = cur_number;
    entryLetterNext = entry_letter;
    entryNumberNext = entry_number;
    entryValidNext  = 1'b0;
    badKeyNext      = 1'b0;
    timeoutNext     = 1'b0;
    if (isMake) begin
      case (state)
        IDLE: begin
          if (isLetter) curLetterNext = letterIdx;
          else if (!isEdit) badKeyNext = 1'b1;
        end
        GOT_LETTER: begin
          if (isLetter) curLetterNext = letterIdx;
          else if (isDigit) curNumberNext = digitIdx;
          else if (!isEdit) badKeyNext = 1'b1;
        end
        GOT_NUMBER: begin
          if (isEnter) begin
            entryLetterNext = cur_letter;
            entryNumberNext = cur_number;
            entryValidNext  = 1'b1;
          end else if (isDigit) begin
            curNumberNext = digitIdx;
          end else if (!isEdit) begin
            badKeyNext = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (timeoutHit) begin
      timeoutNext = 1'b1;
    end
    // Every route back to IDLE discards the partial entry.
    if (stateNext == IDLE) begin
      curLetterNext = 4'd0;
      curNumberNext = 4'd0;
    end
  end

endmodule
